au_sequencer: RTL and testbench

AU_SEQUENCER -- requirements
Module: au_sequencer

---
 rtl/au_sequencer_if.sv | 35 +++
 rtl/au_sequencer.sv | 119 +++++++++++
 tb/tb_au_sequencer.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/au_sequencer_if.sv
// Command, arithmetic-unit and result bundle for au_sequencer.
// The slave modport is the sequencer; the master modport is the command/result side.
interface au_sequencer_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_load;
  logic [2:0] cmd_op;
  logic       cmd_chain;
  logic [7:0] cmd_data;
  logic [7:0] au_x;
  logic [7:0] au_y;
  logic       au_sel1;
  logic       au_sel0;
  logic       au_cin;
  logic [7:0] au_f;
  logic       au_cout;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_data;
  logic       res_cout;
  logic       res_zero;
  logic [7:0] op_count;

  modport slave (
    input  cmd_valid, cmd_load, cmd_op, cmd_chain, cmd_data, au_f, au_cout, res_ready,
    output cmd_ready, au_x, au_y, au_sel1, au_sel0, au_cin,
           res_valid, res_data, res_cout, res_zero, op_count
  );

  modport master (
    output cmd_valid, cmd_load, cmd_op, cmd_chain, cmd_data, au_f, au_cout, res_ready,
    input  cmd_ready, au_x, au_y, au_sel1, au_sel0, au_cin,
           res_valid, res_data, res_cout, res_zero, op_count
  );
endinterface

// File: rtl/au_sequencer.sv
// Sequences load/arithmetic commands through an external combinational arithmetic unit,
// keeping an accumulator and a chainable carry, and presents each result via a handshake.
module au_sequencer (
  input logic           clk,
  input logic           rst_n,
  au_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    RESULT = 2'd2
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [7:0] acc_r;
  logic       carry_r;
  logic [7:0] au_x_r;
  logic [7:0] au_y_r;
  logic       au_sel1_r;
  logic       au_sel0_r;
  logic       au_cin_r;
  logic       cmd_ready_r;
  logic       res_valid_r;
  logic [7:0] res_data_r;
  logic       res_cout_r;
  logic       res_zero_r;
  logic [7:0] op_count_r;

  // Next-state decode; commands outside IDLE are simply not looked at.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          state_s = bus.cmd_load ? RESULT : ISSUE;
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE:  state_s = RESULT;
      RESULT: begin
        if (bus.res_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RESULT;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register plus handshake flags registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      cmd_ready_r <= 1'b1;
      res_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cmd_ready_r <= (state_s == IDLE);
      res_valid_r <= (state_s == RESULT);
    end
  end

  // Datapath: operands are launched at acceptance, results captured one edge later.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r      <= 8'h00;
      carry_r    <= 1'b0;
      au_x_r     <= 8'h00;
      au_y_r     <= 8'h00;
      au_sel1_r  <= 1'b0;
      au_sel0_r  <= 1'b0;
      au_cin_r   <= 1'b0;
      res_data_r <= 8'h00;
      res_cout_r <= 1'b0;
      res_zero_r <= 1'b1;
      op_count_r <= 8'h00;
    end else begin
      if ((state_r == IDLE) && bus.cmd_valid && !bus.cmd_load) begin
        au_x_r    <= acc_r;
        au_y_r    <= bus.cmd_data;
        au_sel1_r <= bus.cmd_op[2];
        au_sel0_r <= bus.cmd_op[1];
        au_cin_r  <= bus.cmd_chain ? carry_r : bus.cmd_op[0];
      end
      if ((state_r == IDLE) && bus.cmd_valid && bus.cmd_load) begin
        acc_r      <= bus.cmd_data;
        res_data_r <= bus.cmd_data;
        res_cout_r <= 1'b0;
        carry_r    <= 1'b0;
        res_zero_r <= (bus.cmd_data == 8'h00);
      end
      if (state_r == ISSUE) begin
        acc_r      <= bus.au_f;
        res_data_r <= bus.au_f;
        res_cout_r <= bus.au_cout;
        carry_r    <= bus.au_cout;
        res_zero_r <= (bus.au_f == 8'h00);
        op_count_r <= op_count_r + 8'd1;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.res_valid = res_valid_r;
  assign bus.au_x      = au_x_r;
  assign bus.au_y      = au_y_r;
  assign bus.au_sel1   = au_sel1_r;
  assign bus.au_sel0   = au_sel0_r;
  assign bus.au_cin    = au_cin_r;
  assign bus.res_data  = res_data_r;
  assign bus.res_cout  = res_cout_r;
  assign bus.res_zero  = res_zero_r;
  assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_au_sequencer.sv
// Directed bench for au_sequencer with a behavioural arithmetic unit driving au_f/au_cout.
module tb_au_sequencer;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;
  logic [8:0] sum_s;

  au_sequencer_if bus ();

  au_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural arithmetic unit, written from its documented function table.
  always_comb begin
    sum_s = 9'd0;
    case ({bus.au_sel1, bus.au_sel0})
      2'b00:   sum_s = {1'b0, bus.au_x} + {8'd0, bus.au_cin};
      2'b01:   sum_s = {1'b0, bus.au_x} + {1'b0, bus.au_y} + {8'd0, bus.au_cin};
      2'b10:   sum_s = {1'b0, bus.au_x} + {1'b0, ~bus.au_y} + {8'd0, ~bus.au_cin};
      default: sum_s = {1'b0, bus.au_x} + 9'h0FF + {8'd0, bus.au_cin};
    endcase
  end
  assign bus.au_f    = sum_s[7:0];
  assign bus.au_cout = sum_s[8];

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Offer one command for exactly one cycle; returns at the negedge after acceptance.
  task automatic send(input logic ld, input logic [2:0] op, input logic ch, input logic [7:0] d);
    @(negedge clk);
    chk1("cmd_ready_before", bus.cmd_ready, 1'b1);
    bus.cmd_valid = 1'b1;
    bus.cmd_load  = ld;
    bus.cmd_op    = op;
    bus.cmd_chain = ch;
    bus.cmd_data  = d;
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  // Called in ISSUE: result must appear exactly one cycle later.
  task automatic op_check(input logic [7:0] d, input logic c, input logic z, input logic [7:0] cnt);
    chk1("issue_no_valid", bus.res_valid, 1'b0);
    @(negedge clk);
    chk1("res_valid", bus.res_valid, 1'b1);
    chk8("res_data", bus.res_data, d);
    chk1("res_cout", bus.res_cout, c);
    chk1("res_zero", bus.res_zero, z);
    chk8("op_count", bus.op_count, cnt);
  endtask

  task automatic take();
    bus.res_ready = 1'b1;
    @(negedge clk);
    bus.res_ready = 1'b0;
    chk1("idle_ready", bus.cmd_ready, 1'b1);
    chk1("idle_no_valid", bus.res_valid, 1'b0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    bus.cmd_op    = 3'b000;
    bus.cmd_chain = 1'b0;
    bus.cmd_data  = 8'h00;
    bus.res_ready = 1'b0;
    repeat (2) @(negedge clk);

    chk1("rst_cmd_ready", bus.cmd_ready, 1'b1);
    chk1("rst_res_valid", bus.res_valid, 1'b0);
    chk1("rst_res_zero", bus.res_zero, 1'b1);
    chk1("rst_res_cout", bus.res_cout, 1'b0);
    chk8("rst_res_data", bus.res_data, 8'h00);
    chk8("rst_op_count", bus.op_count, 8'h00);
    chk8("rst_au_x", bus.au_x, 8'h00);
    chk8("rst_au_y", bus.au_y, 8'h00);
    chk1("rst_au_sel1", bus.au_sel1, 1'b0);
    chk1("rst_au_sel0", bus.au_sel0, 1'b0);
    chk1("rst_au_cin", bus.au_cin, 1'b0);
    rst_n = 1'b1;

    // Load (chain ignored on load), then add.
    send(1'b1, 3'b000, 1'b1, 8'h24);
    chk1("load_valid", bus.res_valid, 1'b1);
    chk8("load_data", bus.res_data, 8'h24);
    chk1("load_cout", bus.res_cout, 1'b0);
    chk1("load_zero", bus.res_zero, 1'b0);
    chk8("load_count", bus.op_count, 8'h00);
    take();
    send(1'b0, 3'b010, 1'b0, 8'h18);
    chk8("add_au_x", bus.au_x, 8'h24);
    chk8("add_au_y", bus.au_y, 8'h18);
    chk1("add_sel1", bus.au_sel1, 1'b0);
    chk1("add_sel0", bus.au_sel0, 1'b1);
    chk1("add_cin", bus.au_cin, 1'b0);
    op_check(8'h3C, 1'b0, 1'b0, 8'h01);
    take();

    // Subtract.
    send(1'b1, 3'b000, 1'b0, 8'h24);
    take();
    send(1'b0, 3'b100, 1'b0, 8'h18);
    op_check(8'h0C, 1'b1, 1'b0, 8'h02);
    take();

    // Decrement of zero, then increment wraps to zero.
    send(1'b1, 3'b000, 1'b0, 8'h00);
    chk1("load0_zero", bus.res_zero, 1'b1);
    take();
    send(1'b0, 3'b110, 1'b0, 8'h00);
    op_check(8'hFF, 1'b0, 1'b0, 8'h03);
    take();
    send(1'b0, 3'b001, 1'b0, 8'h00);
    op_check(8'h00, 1'b1, 1'b1, 8'h04);
    take();

    // Carry chaining.
    send(1'b1, 3'b000, 1'b0, 8'hFF);
    take();
    send(1'b0, 3'b010, 1'b0, 8'h01);
    op_check(8'h00, 1'b1, 1'b1, 8'h05);
    take();
    send(1'b0, 3'b010, 1'b1, 8'h00);
    chk1("chain_cin", bus.au_cin, 1'b1);
    op_check(8'h01, 1'b0, 1'b0, 8'h06);

    // Back-pressure: result holds and commands are ignored.
    for (int i = 0; i < 5; i++) begin
      bus.cmd_valid = 1'b1;
      bus.cmd_load  = 1'b1;
      bus.cmd_data  = 8'h55;
      @(negedge clk);
      chk1("hold_valid", bus.res_valid, 1'b1);
      chk1("hold_ready", bus.cmd_ready, 1'b0);
      chk8("hold_data", bus.res_data, 8'h01);
      chk1("hold_cout", bus.res_cout, 1'b0);
      chk8("hold_count", bus.op_count, 8'h06);
    end
    bus.cmd_valid = 1'b0;
    bus.cmd_load  = 1'b0;
    take();
    send(1'b0, 3'b000, 1'b0, 8'h00);
    chk8("acc_kept", bus.au_x, 8'h01);
    op_check(8'h01, 1'b0, 1'b0, 8'h07);
    take();

    // Reset during ISSUE with acc and carry non-zero.
    send(1'b1, 3'b000, 1'b0, 8'hF0);
    take();
    send(1'b0, 3'b010, 1'b0, 8'h20);
    op_check(8'h10, 1'b1, 1'b0, 8'h08);
    take();
    send(1'b0, 3'b000, 1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    chk1("abort_valid", bus.res_valid, 1'b0);
    chk8("abort_count", bus.op_count, 8'h00);
    chk8("abort_data", bus.res_data, 8'h00);
    chk8("abort_au_x", bus.au_x, 8'h00);
    chk1("abort_zero", bus.res_zero, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    send(1'b0, 3'b000, 1'b1, 8'h00);
    chk8("post_rst_au_x", bus.au_x, 8'h00);
    chk1("post_rst_cin", bus.au_cin, 1'b0);
    op_check(8'h00, 1'b0, 1'b1, 8'h01);
    take();

    // Counter wrap after 256 operations since reset.
    for (int i = 2; i < 255; i++) begin
      send(1'b0, 3'b000, 1'b0, 8'h00);
      @(negedge clk);
      take();
    end
    send(1'b0, 3'b000, 1'b0, 8'h00);
    op_check(8'h00, 1'b0, 1'b1, 8'hFF);
    take();
    send(1'b0, 3'b000, 1'b0, 8'h00);
    op_check(8'h00, 1'b0, 1'b1, 8'h00);
    take();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
